// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// States, opcodes, datapath mux codes and the branch-taken rule.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JALRADR,
    S_JUMP,
    S_UPPER,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    AOP_ADD,
    AOP_SUB,
    AOP_FUNCT,
    AOP_PASSB
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Without full branch support only beq/bne can ever be taken.
  function automatic logic br_taken(
    input logic [2:0] f3,
    input logic       zero,
    input logic       lt,
    input logic       ltu,
    input logic       full
  );
    logic t;
    case (f3)
      3'b000:  t = zero;
      3'b001:  t = ~zero;
      3'b100:  t = lt;
      3'b101:  t = ~lt;
      3'b110:  t = ltu;
      3'b111:  t = ~ltu;
      default: t = 1'b0;
    endcase
    if (!full && f3[2]) t = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select from the FSM's ALU mode and instruction fields.
// funct7[5] selects SUB only for register-register operations.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  input  aluop_t     i_aluop,
  output logic [3:0] o_alu_ctrl
);

  // Map ALU mode and funct fields to the ALU control code
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    unique case (i_aluop)
      AOP_ADD:   o_alu_ctrl = ALU_ADD;
      AOP_SUB:   o_alu_ctrl = ALU_SUB;
      AOP_PASSB: o_alu_ctrl = ALU_PASSB;
      AOP_FUNCT: begin
        case (i_funct3)
          3'b000: o_alu_ctrl = (i_op[5] && i_funct7_5)
                               ? ALU_SUB : ALU_ADD;
          3'b001: o_alu_ctrl = ALU_SLL;
          3'b010: o_alu_ctrl = ALU_SLT;
          3'b011: o_alu_ctrl = ALU_SLTU;
          3'b100: o_alu_ctrl = ALU_XOR;
          3'b101: o_alu_ctrl = i_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: o_alu_ctrl = ALU_OR;
          default: o_alu_ctrl = ALU_AND;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I control FSM over one shared memory port.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap (Illegal_o).
module multicycle_controlunit
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FULL_BRANCH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] Instr_i,
  input  logic                  Zero_i,
  input  logic                  LT_i,
  input  logic                  LTU_i,
  input  logic                  MemReady_i,
  output logic                  PCWrite_o,
  output logic                  IRWrite_o,
  output logic                  AdrSrc_o,
  output logic                  MemWrite_o,
  output logic                  RegWrite_o,
  output logic [1:0]            ResultSrc_o,
  output logic [1:0]            ALUSrcA_o,
  output logic [1:0]            ALUSrcB_o,
  output logic [2:0]            ImmSrc_o,
  output logic [3:0]            ALUCtrl_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                  Illegal_o
`endif
);

  state_t     r_state;
  state_t     w_next;
  aluop_t     w_aluop;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7;
  logic       w_pcw;
  logic       w_irw;
  logic       w_mw;
  logic       w_rw;
  logic       w_full;
  logic       w_unused;

  assign w_op     = Instr_i[6:0];
  assign w_f3     = Instr_i[14:12];
  assign w_f7     = Instr_i[30];
  assign w_full   = (FULL_BRANCH != 0);
  assign w_unused = ^{Instr_i[DATA_WIDTH-1:31],
                      Instr_i[29:15], Instr_i[11:7]};

  // State register; reset aborts any instruction back to FETCH
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next state and Moore outputs, plus the branch-taken PC enable
  always_comb begin
    w_next      = r_state;
    w_pcw       = 1'b0;
    w_irw       = 1'b0;
    w_mw        = 1'b0;
    w_rw        = 1'b0;
    AdrSrc_o    = 1'b0;
    ResultSrc_o = RES_ALUOUT;
    ALUSrcA_o   = SRCA_PC;
    ALUSrcB_o   = SRCB_RD2;
    ImmSrc_o    = IMM_I;
    w_aluop     = AOP_ADD;
    unique case (r_state)
      S_FETCH: begin
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURES;
        w_irw       = MemReady_i;
        w_pcw       = MemReady_i;
        if (MemReady_i) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = (w_op == OP_JAL) ? IMM_J : IMM_B;
        case (w_op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_IMM:            w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JUMP;
          OP_JALR:           w_next = S_JALRADR;
          OP_LUI, OP_AUIPC:  w_next = S_UPPER;
`ifdef ILLEGAL_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        if (w_op == OP_STORE) begin
          ImmSrc_o = IMM_S;
          w_next   = S_MEMWRITE;
        end else begin
          w_next   = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        AdrSrc_o = 1'b1;
        if (MemReady_i) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_o = RES_READ;
        w_rw        = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc_o = 1'b1;
        w_mw     = 1'b1;
        if (MemReady_i) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA_o = SRCA_RD1;
        w_aluop   = AOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        w_aluop   = AOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o = SRCA_RD1;
        w_aluop   = AOP_SUB;
        w_pcw     = br_taken(w_f3, Zero_i, LT_i, LTU_i, w_full);
        w_next    = S_FETCH;
      end
      S_JALRADR: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        w_next    = S_JUMP;
      end
      S_JUMP: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_FOUR;
        w_pcw     = 1'b1;
        w_next    = S_ALUWB;
      end
      S_UPPER: begin
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = IMM_U;
        if (w_op == OP_LUI) begin
          ALUSrcA_o = SRCA_RD1;
          w_aluop   = AOP_PASSB;
        end else begin
          ALUSrcA_o = SRCA_OLDPC;
        end
        w_next = S_ALUWB;
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        w_next = S_TRAP;
`else
        w_next = S_FETCH;
`endif
      end
    endcase
  end

  assign PCWrite_o  = w_pcw & ~rst_i;
  assign IRWrite_o  = w_irw & ~rst_i;
  assign MemWrite_o = w_mw & ~rst_i;
  assign RegWrite_o = w_rw & ~rst_i;

`ifdef ILLEGAL_TRAP_EN
  assign Illegal_o = (r_state == S_TRAP);
`endif

  alu_decoder u_alu_dec (
    .i_op       (w_op),
    .i_funct3   (w_f3),
    .i_funct7_5 (w_f7),
    .i_aluop    (w_aluop),
    .o_alu_ctrl (ALUCtrl_o)
  );

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Bench for multicycle_controlunit: vector table, corner sequences,
// and random instruction streams against a reference model.
module tb_multicycle_controlunit;

  typedef logic [17:0] outs_t;
  typedef string plan_t[$];

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        z;
    logic        lt;
    logic        ltu;
    logic        mr;
    outs_t       e1;
    outs_t       e0;
    string       nm;
  } vec_t;

  // {PCWrite,IRWrite,AdrSrc,MemWrite,RegWrite,Res,A,B,Imm,ALU}
  localparam outs_t O_F1   = {5'b11000, 2'd2, 2'd0, 2'd2, 3'd0, 4'd0};
  localparam outs_t O_F0   = {5'b00000, 2'd2, 2'd0, 2'd2, 3'd0, 4'd0};
  localparam outs_t O_DEC  = {5'b00000, 2'd0, 2'd1, 2'd1, 3'd2, 4'd0};
  localparam outs_t O_DECJ = {5'b00000, 2'd0, 2'd1, 2'd1, 3'd4, 4'd0};
  localparam outs_t O_XI   = {5'b00000, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0};
  localparam outs_t O_WB   = {5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0};
  localparam outs_t O_BRT  = {5'b10000, 2'd0, 2'd2, 2'd0, 3'd0, 4'd1};
  localparam outs_t O_BRN  = {5'b00000, 2'd0, 2'd2, 2'd0, 3'd0, 4'd1};
  localparam outs_t O_J    = {5'b10000, 2'd0, 2'd1, 2'd2, 3'd0, 4'd0};
  localparam outs_t O_MAL  = {5'b00000, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0};
  localparam outs_t O_MAS  = {5'b00000, 2'd0, 2'd2, 2'd1, 3'd1, 4'd0};
  localparam outs_t O_MR   = {5'b00100, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0};
  localparam outs_t O_MWB  = {5'b00001, 2'd1, 2'd0, 2'd0, 3'd0, 4'd0};
  localparam outs_t O_MW   = {5'b00110, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0};

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h00802103;
  localparam logic [31:0] I_SW   = 32'h00202223;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_BLTU = 32'h00006463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] Instr = '0;
  logic        Zero = 1'b0;
  logic        LT = 1'b0;
  logic        LTU = 1'b0;
  logic        MemReady = 1'b0;

  logic       pcw1, irw1, adr1, mw1, rw1;
  logic [1:0] res1, a1, b1;
  logic [2:0] imm1;
  logic [3:0] alu1;
  logic       pcw0, irw0, adr0, mw0, rw0;
  logic [1:0] res0, a0, b0;
  logic [2:0] imm0;
  logic [3:0] alu0;
`ifdef ILLEGAL_TRAP_EN
  logic       ill1, ill0;
`endif

  outs_t act1, act0;
  assign act1 = {pcw1, irw1, adr1, mw1, rw1, res1, a1, b1, imm1, alu1};
  assign act0 = {pcw0, irw0, adr0, mw0, rw0, res0, a0, b0, imm0, alu0};

  multicycle_controlunit #(.DATA_WIDTH(32), .FULL_BRANCH(1)) dut (
    .clk_i(clk), .rst_i(rst), .Instr_i(Instr),
    .Zero_i(Zero), .LT_i(LT), .LTU_i(LTU), .MemReady_i(MemReady),
    .PCWrite_o(pcw1), .IRWrite_o(irw1), .AdrSrc_o(adr1),
    .MemWrite_o(mw1), .RegWrite_o(rw1), .ResultSrc_o(res1),
    .ALUSrcA_o(a1), .ALUSrcB_o(b1), .ImmSrc_o(imm1),
    .ALUCtrl_o(alu1)
`ifdef ILLEGAL_TRAP_EN
    , .Illegal_o(ill1)
`endif
  );

  multicycle_controlunit #(.DATA_WIDTH(32), .FULL_BRANCH(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .Instr_i(Instr),
    .Zero_i(Zero), .LT_i(LT), .LTU_i(LTU), .MemReady_i(MemReady),
    .PCWrite_o(pcw0), .IRWrite_o(irw0), .AdrSrc_o(adr0),
    .MemWrite_o(mw0), .RegWrite_o(rw0), .ResultSrc_o(res0),
    .ALUSrcA_o(a0), .ALUSrcB_o(b0), .ImmSrc_o(imm0),
    .ALUCtrl_o(alu0)
`ifdef ILLEGAL_TRAP_EN
    , .Illegal_o(ill0)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // One clock: drive after posedge, compare at negedge.
  task automatic cyc(input logic r, input logic [31:0] ins,
                     input logic z, input logic lt,
                     input logic ltu, input logic mr,
                     input outs_t e1, input outs_t e0,
                     input logic ill, input string nm);
    rst = r; Instr = ins; Zero = z; LT = lt; LTU = ltu;
    MemReady = mr;
    @(negedge clk);
    n_chk++;
    if (act1 !== e1) begin
      n_fail++;
      $display("FAIL %s fb1: got %h want %h", nm, act1, e1);
    end
    n_chk++;
    if (act0 !== e0) begin
      n_fail++;
      $display("FAIL %s fb0: got %h want %h", nm, act0, e0);
    end
`ifdef ILLEGAL_TRAP_EN
    n_chk++;
    if (ill1 !== ill || ill0 !== ill) begin
      n_fail++;
      $display("FAIL %s illegal: got %b/%b want %b",
               nm, ill1, ill0, ill);
    end
`else
    if (ill) $display("note: illegal flag unused in %s", nm);
`endif
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic r, input logic [31:0] ins,
                               input logic z, input logic lt,
                               input logic ltu, input logic mr,
                               input outs_t e1, input outs_t e0,
                               input string nm);
    vec_t v;
    v.rst = r; v.ins = ins; v.z = z; v.lt = lt; v.ltu = ltu;
    v.mr = mr; v.e1 = e1; v.e0 = e0; v.nm = nm;
    return v;
  endfunction

  // Reference: ALU code from the instruction's arithmetic meaning.
  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    logic [3:0] v;
    int f3;
    f3 = int'(ins[14:12]);
    case (f3)
      0: v = 4'd0;
      1: v = 4'd5;
      2: v = 4'd8;
      3: v = 4'd9;
      4: v = 4'd4;
      5: v = 4'd6;
      6: v = 4'd3;
      default: v = 4'd2;
    endcase
    if (ins[30] && f3 == 5) v = 4'd7;
    if (ins[30] && f3 == 0 && ins[6:0] == 7'd51) v = 4'd1;
    return v;
  endfunction

  function automatic logic ref_taken(input logic [31:0] ins,
                                     input logic z, input logic lt,
                                     input logic ltu, input bit fb);
    logic t;
    int f3;
    f3 = int'(ins[14:12]);
    case (f3)
      0: t = z;
      1: t = !z;
      4: t = lt;
      5: t = !lt;
      6: t = ltu;
      7: t = !ltu;
      default: t = 1'b0;
    endcase
    if (!fb && f3 > 1) t = 1'b0;
    return t;
  endfunction

  // Sequence of phases an instruction passes through.
  function automatic plan_t plan(input logic [31:0] ins);
    plan_t p;
    case (ins[6:0])
      7'd3:   p = '{"F", "D", "MA", "MR", "MWB"};
      7'd35:  p = '{"F", "D", "MA", "MW"};
      7'd51:  p = '{"F", "D", "XR", "WB"};
      7'd19:  p = '{"F", "D", "XI", "WB"};
      7'd99:  p = '{"F", "D", "BR"};
      7'd111: p = '{"F", "D", "J", "WB"};
      7'd103: p = '{"F", "D", "JA", "J", "WB"};
      7'd55,
      7'd23:  p = '{"F", "D", "U", "WB"};
      default: p = '{"F", "D"};
    endcase
    return p;
  endfunction

  function automatic outs_t ref_out(input string ph,
                                    input logic [31:0] ins,
                                    input logic z, input logic lt,
                                    input logic ltu, input logic mr,
                                    input bit fb);
    logic [6:0] op;
    logic       tk;
    op = ins[6:0];
    tk = ref_taken(ins, z, lt, ltu, fb);
    if (ph == "F")
      return {mr, mr, 3'b000, 2'd2, 2'd0, 2'd2, 3'd0, 4'd0};
    if (ph == "D")
      return {5'b0, 2'd0, 2'd1, 2'd1,
              (op == 7'd111) ? 3'd4 : 3'd2, 4'd0};
    if (ph == "MA")
      return {5'b0, 2'd0, 2'd2, 2'd1,
              (op == 7'd35) ? 3'd1 : 3'd0, 4'd0};
    if (ph == "MR") return O_MR;
    if (ph == "MWB") return O_MWB;
    if (ph == "MW") return O_MW;
    if (ph == "XR")
      return {5'b0, 2'd0, 2'd2, 2'd0, 3'd0, ref_alu(ins)};
    if (ph == "XI")
      return {5'b0, 2'd0, 2'd2, 2'd1, 3'd0, ref_alu(ins)};
    if (ph == "WB") return O_WB;
    if (ph == "BR")
      return {tk, 4'b0, 2'd0, 2'd2, 2'd0, 3'd0, 4'd1};
    if (ph == "JA") return O_MAL;
    if (ph == "J") return O_J;
    if (op == 7'd55)
      return {5'b0, 2'd0, 2'd2, 2'd1, 3'd3, 4'd10};
    return {5'b0, 2'd0, 2'd1, 2'd1, 3'd3, 4'd0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [0:9];
    logic [31:0] ins;
    int          hi;
    ops = '{7'd3, 7'd19, 7'd23, 7'd35, 7'd51,
            7'd55, 7'd99, 7'd103, 7'd111, 7'h0F};
`ifdef ILLEGAL_TRAP_EN
    hi = 8;
`else
    hi = 9;
`endif
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, hi)];
    return ins;
  endfunction

  vec_t tbl[$];

  initial begin
    tbl.push_back(mkv(1, I_ADDI, 0, 0, 0, 1, O_F0, O_F0, "rst_fetch"));
    tbl.push_back(mkv(0, I_ADDI, 0, 0, 0, 0, O_F0, O_F0, "fetch_wait"));
    tbl.push_back(mkv(0, I_ADDI, 0, 0, 0, 1, O_F1, O_F1, "addi_f"));
    tbl.push_back(mkv(0, I_ADDI, 0, 0, 0, 1, O_DEC, O_DEC, "addi_d"));
    tbl.push_back(mkv(0, I_ADDI, 0, 0, 0, 1, O_XI, O_XI, "addi_x"));
    tbl.push_back(mkv(0, I_ADDI, 0, 0, 0, 1, O_WB, O_WB, "addi_wb"));
    tbl.push_back(mkv(0, I_BEQ, 1, 0, 0, 1, O_F1, O_F1, "beq_f"));
    tbl.push_back(mkv(0, I_BEQ, 1, 0, 0, 1, O_DEC, O_DEC, "beq_d"));
    tbl.push_back(mkv(0, I_BEQ, 1, 0, 0, 0, O_BRT, O_BRT, "beq_tk"));
    tbl.push_back(mkv(0, I_BEQ, 0, 0, 0, 1, O_F1, O_F1, "beq_f2"));
    tbl.push_back(mkv(0, I_BEQ, 0, 0, 0, 1, O_DEC, O_DEC, "beq_d2"));
    tbl.push_back(mkv(0, I_BEQ, 0, 1, 1, 1, O_BRN, O_BRN, "beq_nt"));
    tbl.push_back(mkv(0, I_BLTU, 0, 0, 1, 1, O_F1, O_F1, "bltu_f"));
    tbl.push_back(mkv(0, I_BLTU, 0, 0, 1, 1, O_DEC, O_DEC, "bltu_d"));
    tbl.push_back(mkv(0, I_BLTU, 0, 0, 1, 1, O_BRT, O_BRN, "bltu_br"));
    tbl.push_back(mkv(0, I_JAL, 0, 0, 0, 1, O_F1, O_F1, "jal_f"));
    tbl.push_back(mkv(0, I_JAL, 0, 0, 0, 0, O_DECJ, O_DECJ, "jal_d"));
    tbl.push_back(mkv(0, I_JAL, 0, 0, 0, 0, O_J, O_J, "jal_j"));
    tbl.push_back(mkv(0, I_JAL, 0, 0, 0, 0, O_WB, O_WB, "jal_wb"));

    @(posedge clk);
    #1;
    foreach (tbl[i])
      cyc(tbl[i].rst, tbl[i].ins, tbl[i].z, tbl[i].lt, tbl[i].ltu,
          tbl[i].mr, tbl[i].e1, tbl[i].e0, 1'b0, tbl[i].nm);

    // Load with three wait cycles in MEMREAD.
    cyc(0, I_LW, 0, 0, 0, 1, O_F1, O_F1, 0, "lw_f");
    cyc(0, I_LW, 0, 0, 0, 0, O_DEC, O_DEC, 0, "lw_d");
    cyc(0, I_LW, 0, 0, 0, 0, O_MAL, O_MAL, 0, "lw_ma");
    for (int k = 0; k < 3; k++)
      cyc(0, I_LW, 0, 0, 0, 0, O_MR, O_MR, 0, "lw_mr_wait");
    cyc(0, I_LW, 0, 0, 0, 1, O_MR, O_MR, 0, "lw_mr_done");
    cyc(0, I_LW, 0, 0, 0, 1, O_MWB, O_MWB, 0, "lw_wb");

    // Store with two wait cycles in MEMWRITE.
    cyc(0, I_SW, 0, 0, 0, 1, O_F1, O_F1, 0, "sw_f");
    cyc(0, I_SW, 0, 0, 0, 1, O_DEC, O_DEC, 0, "sw_d");
    cyc(0, I_SW, 0, 0, 0, 1, O_MAS, O_MAS, 0, "sw_ma");
    for (int k = 0; k < 2; k++)
      cyc(0, I_SW, 0, 0, 0, 0, O_MW, O_MW, 0, "sw_mw_wait");
    cyc(0, I_SW, 0, 0, 0, 1, O_MW, O_MW, 0, "sw_mw_done");
    cyc(0, I_SW, 0, 0, 0, 0, O_F0, O_F0, 0, "sw_back");

    // Reset in the middle of a store wait: no partial MemWrite.
    cyc(0, I_SW, 0, 0, 0, 1, O_F1, O_F1, 0, "swr_f");
    cyc(0, I_SW, 0, 0, 0, 1, O_DEC, O_DEC, 0, "swr_d");
    cyc(0, I_SW, 0, 0, 0, 1, O_MAS, O_MAS, 0, "swr_ma");
    cyc(0, I_SW, 0, 0, 0, 0, O_MW, O_MW, 0, "swr_mw");
    cyc(1, I_SW, 0, 0, 0, 1, O_F0, O_F0, 0, "swr_rst");
    cyc(0, I_SW, 0, 0, 0, 1, O_F1, O_F1, 0, "swr_refetch");

    // Reset in the middle of a load: returns to FETCH.
    cyc(0, I_LW, 0, 0, 0, 1, O_DEC, O_DEC, 0, "lwr_d");
    cyc(0, I_LW, 0, 0, 0, 1, O_MAL, O_MAL, 0, "lwr_ma");
    cyc(1, I_LW, 0, 0, 0, 1, O_F0, O_F0, 0, "lwr_rst");
    cyc(0, I_LW, 0, 0, 0, 1, O_F1, O_F1, 0, "lwr_refetch");
    cyc(0, I_ADDI, 0, 0, 0, 1, O_DEC, O_DEC, 0, "lwr_d2");
    cyc(0, I_ADDI, 0, 0, 0, 1, O_XI, O_XI, 0, "lwr_x");
    cyc(0, I_ADDI, 0, 0, 0, 1, O_WB, O_WB, 0, "lwr_wb");

    // Random instruction stream against the reference model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ins;
      plan_t       p;
      int          idx;
      int          waits;
      ins = rand_instr();
      p = plan(ins);
      idx = 0;
      waits = 0;
      while (idx < p.size()) begin
        logic z, lt, ltu, mr;
        string ph;
        bit stall;
        z = 1'($urandom_range(0, 1));
        lt = 1'($urandom_range(0, 1));
        ltu = 1'($urandom_range(0, 1));
        mr = ($urandom_range(0, 3) != 0) || (waits > 6);
        ph = p[idx];
        cyc(0, ins, z, lt, ltu, mr,
            ref_out(ph, ins, z, lt, ltu, mr, 1'b1),
            ref_out(ph, ins, z, lt, ltu, mr, 1'b0),
            0, ph);
        stall = (ph == "F" || ph == "MR" || ph == "MW") && !mr;
        if (stall) begin
          waits++;
        end else begin
          idx++;
          waits = 0;
        end
      end
    end

    // Unknown opcode.
    cyc(0, 32'h0, 0, 0, 0, 1, O_F1, O_F1, 0, "ill_f");
    cyc(0, 32'h0, 0, 0, 0, 1, O_DEC, O_DEC, 0, "ill_d");
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++)
      cyc(0, 32'h0, 1, 1, 1, 1, '0, '0, 1, "trap_hold");
    cyc(1, 32'h0, 0, 0, 0, 1, O_F0, O_F0, 0, "trap_rst");
    cyc(0, I_ADDI, 0, 0, 0, 1, O_F1, O_F1, 0, "trap_exit");
`else
    cyc(0, 32'h0, 0, 0, 0, 0, O_F0, O_F0, 0, "nop_fetch");
    cyc(0, I_ADDI, 0, 0, 0, 1, O_F1, O_F1, 0, "nop_next");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controlunit.md
Name: multicycle_controlunit

Overview:
Multi-cycle RV32I control FSM that replaces the single-cycle decoder. It sequences FETCH/DECODE/EXECUTE/MEM/WB over several cycles on one shared memory port, with a memory-ready handshake. It drives datapath enables and mux selects (PCWrite, IRWrite, AdrSrc, ALUSrcA/B), and supports all six branch conditions plus jal/jalr/lui/auipc.

Parameters:
DATA_WIDTH, 32, instruction width.
FULL_BRANCH, 1, 1 = beq/bne/blt/bge/bltu/bgeu; 0 = beq/bne only (other funct3 not taken).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
Instr_i  in  DATA_WIDTH  instruction register contents
Zero_i  in  1  ALU result == 0
LT_i  in  1  signed rs1 < rs2
LTU_i  in  1  unsigned rs1 < rs2
MemReady_i  in  1  memory access completes this cycle
PCWrite_o  out  1  PC register enable
IRWrite_o  out  1  instruction register / OldPC enable
AdrSrc_o  out  1  0 = PC, 1 = ALUOut as memory address
MemWrite_o  out  1  memory write strobe
RegWrite_o  out  1  register file write enable
ResultSrc_o  out  2  00 ALUOut, 01 ReadData, 10 ALUResult
ALUSrcA_o  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB_o  out  2  00 RD2, 01 Imm, 10 constant 4
ImmSrc_o  out  3  000 I, 001 S, 010 B, 011 U, 100 J
ALUCtrl_o  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010

Behaviour:
- Moore FSM plus a combinational branch-taken term. One state register. Reset puts the FSM in FETCH. While rst_i is high, PCWrite/IRWrite/MemWrite/RegWrite are 0; the muxes hold their FETCH values.
- Unlisted outputs are 0 (ALUCtrl ADD).
- FETCH: AdrSrc=0, A=00, B=10, ADD, ResultSrc=10. IRWrite = PCWrite = MemReady_i. Stay in FETCH until MemReady_i, then go to DECODE.
- DECODE: A=01, B=01, ADD, ImmSrc=J for jal, otherwise B. This computes the target into ALUOut. Next state by opcode: 3/35 go to MEMADR, 51 to EXECR, 19 to EXECI, 99 to BRANCH, 111 to JUMP, 103 to JALRADR, 55/23 to UPPER, any other opcode to ILLEGAL handling.
- MEMADR: A=10, B=01, ImmSrc = I (load) or S (store), ADD. Next is MEMREAD (load) or MEMWRITE (store).
- MEMREAD: AdrSrc=1, ResultSrc=00. Wait for MemReady_i, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held every cycle until MemReady_i, then FETCH.
- EXECR: A=10, B=00, then ALUWB. ALUCtrl from funct3:
  - 000: SUB if funct7[5], else ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRA if funct7[5], else SRL.
  - 110 OR, 111 AND.
- EXECI: A=10, B=01, ImmSrc=I, then ALUWB. ALUCtrl is the same as EXECR, except funct3=000 is always ADD. funct7[5] is used only for 101.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: A=10, B=00, SUB, ResultSrc=00, then FETCH. PCWrite = taken, where taken per funct3 is:
  - 000 Zero_i; 001 !Zero_i
  - 100 LT_i; 101 !LT_i
  - 110 LTU_i; 111 !LTU_i
  - 010/011 never taken
  - with FULL_BRANCH=0, only 000/001 can be taken.
- JALRADR: A=10, B=01, ImmSrc=I, ADD, then JUMP.
- JUMP: A=01, B=10, ADD, ResultSrc=00, PCWrite=1, then ALUWB. This writes rd = OldPC+4.
- UPPER: B=01, ImmSrc=U, then ALUWB. lui: A=10, PASSB. auipc: A=01, ADD.
- MemReady_i is ignored outside FETCH/MEMREAD/MEMWRITE.
- Reset asserted mid-instruction aborts it and returns to FETCH immediately, with no partial RegWrite/MemWrite.
- Cycle counts (MemReady_i tied 1): R/I/upper 4, load 5, store 4, branch 3, jal 4, jalr 5.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an unknown opcode enters TRAP. TRAP is absorbing until reset, with all enables 0 and extra output Illegal_o = 1.
- Undefined: an unknown opcode is treated as a NOP (DECODE goes to FETCH); Illegal_o is absent.

Decomposition:
Shared package ctrl_pkg holds:
- state enum;
- opcode constants (OP_LOAD=3, OP_IMM=19, OP_AUIPC=23, OP_STORE=35, OP_R=51, OP_LUI=55, OP_BRANCH=99, OP_JALR=103, OP_JAL=111);
- ALUCtrl, ImmSrc, ALUSrcA/B and ResultSrc encodings.

One sub-module, alu_decoder: combinational (op, funct3, funct7_5, aluop) to ALUCtrl. The FSM instantiates it.

Test Plan:
- Reset mid-fetch, then 0x00500093 (addi x1,x0,5), MemReady=1 → FETCH, DECODE, EXECI (B=01, ImmSrc=000, ADD), ALUWB (RegWrite=1), FETCH.
- 0x00802103 (lw), MemReady low 3 cycles in MEMREAD → AdrSrc=1 held throughout; MEMWB RegWrite=1, ResultSrc=01.
- 0x00202223 (sw), MemReady low 2 cycles → MemWrite=1 for 3 cycles; RegWrite never 1.
- 0x00000463 (beq) with Zero=1 → PCWrite=1 in BRANCH. With Zero=0 → PCWrite=0. bltu (funct3 110) with LTU=1 and FULL_BRANCH=0 → not taken.
- 0x010000EF (jal) → DECODE ImmSrc=100; JUMP PCWrite=1, A=01, B=10; ALUWB RegWrite=1.
- Instr 0x00000000 → FETCH after DECODE when the macro is undefined. When defined: TRAP, Illegal_o=1, stays until rst_i.
